// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises and debounces the raw BTNU pin for the
// clk148 game logic. Emits a clean level plus one-cycle press/release strobes.
// Optional auto-repeat strobes are built when BTN_AUTO_REPEAT_EN is defined;
// otherwise btn_repeat is tied low and the port list is unchanged.
`timescale 1ns/1ps

module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1485000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 74250000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 14850000
) (
    input  logic clk148,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk148) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with registered level and press/release strobes
    always_ff @(posedge clk148) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= ARM_PRESS;
                        cnt_q   <= '0;
                    end
                end
                ARM_PRESS: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2_q) begin
                        state_q <= ARM_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                ARM_RELEASE: begin
                    if (s2_q) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                       REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_RATE_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              rate_phase_q;
    logic              repeat_q;
    logic              press_fire;
    logic              release_fire;
    logic              held;

    // Decode the FSM edges that start and end a hold
    always_comb begin
        press_fire   = (state_q == ARM_PRESS) && s2_q && (cnt_q == CNT_LAST);
        release_fire = (state_q == ARM_RELEASE) && !s2_q && (cnt_q == CNT_LAST);
        held         = (state_q == PRESSED) || (state_q == ARM_RELEASE);
    end

    // Hold timer: counter restarts at each strobe, first interval is the delay,
    // later intervals the rate; a release-side bounce keeps the running phase
    always_ff @(posedge clk148) begin
        if (!rst_n) begin
            hold_q       <= '0;
            rate_phase_q <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (press_fire || !held || release_fire) begin
                hold_q       <= '0;
                rate_phase_q <= 1'b0;
            end else if (hold_q == (rate_phase_q ? HOLD_NEXT : HOLD_FIRST)) begin
                hold_q       <= '0;
                rate_phase_q <= 1'b1;
                repeat_q     <= 1'b1;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES};
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with small timing overrides.
`timescale 1ns/1ps

module tb_btn_conditioner;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RR = 5;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk148 = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES    (D),
        .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_RATE_CYCLES (RR)
    ) dut (
        .clk148     (clk148),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk148 = ~clk148;

    // Reference model: a level change is accepted once the synchronised input
    // has disagreed with the current level on D+1 consecutive edges; repeats
    // fire at RD, RD+RR, RD+2RR ... edges after the press while held.
    bit m_s1, m_s2, m_level, m_press, m_release, m_repeat;
    int m_run, m_hold;

    always @(posedge clk148) begin
        bit seen;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            m_press = 0; m_release = 0; m_repeat = 0;
            m_run = 0; m_hold = 0;
        end else begin
            m_press = 0; m_release = 0; m_repeat = 0;
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_run = (seen != m_level) ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_run   = 0;
                m_level = seen;
                if (seen) begin
                    m_press = 1;
                    m_hold  = 0;
                end else begin
                    m_release = 1;
                end
            end else if (m_level) begin
                m_hold = m_hold + 1;
                if (m_hold >= RD && ((m_hold - RD) % RR) == 0)
                    m_repeat = REP_EN;
            end
        end
    end

    task automatic tick();
        @(posedge clk148);
        @(negedge clk148);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 1'b1;
        tick();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values: got %b expected 0000",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        tick();
        btn_in = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
    endtask

    task automatic test_clean_press();
        btn_in = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== {k >= 10, k == 10, 1'b0}) begin
                errors++;
                $display("FAIL clean_press k=%0d: got lvl/prs/rel %b expected %b", k,
                         {btn_level, btn_press, btn_release}, {k >= 10, k == 10, 1'b0});
            end
        end
    endtask

    task automatic test_release_bounce();
        for (int k = 0; k <= 20; k++) begin
            btn_in = (k == 3 || k == 4) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== {k < 15, 1'b0, k == 15}) begin
                errors++;
                $display("FAIL release_bounce k=%0d: got lvl/prs/rel %b expected %b", k,
                         {btn_level, btn_press, btn_release}, {k < 15, 1'b0, k == 15});
            end
            checks++;
            if (btn_repeat !== m_repeat) begin
                errors++;
                $display("FAIL release_repeat k=%0d: got %b expected %b", k, btn_repeat, m_repeat);
            end
        end
    endtask

    task automatic test_bounce_reject();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 7; j++) begin
                btn_in = (j < 4) ? 1'b1 : 1'b0;
                tick();
                checks++;
                if ({btn_level, btn_press, btn_release} !== 3'b000) begin
                    errors++;
                    $display("FAIL bounce_reject r=%0d j=%0d: got %b expected 000", r, j,
                             {btn_level, btn_press, btn_release});
                end
            end
        end
        btn_in = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_tail k=%0d: got %b expected 000", k,
                         {btn_level, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_reset_mid_press();
        btn_in = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid k=%0d: got %b expected 0000", k,
                         {btn_level, btn_press, btn_release, btn_repeat});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== {k >= 10, k == 10, 1'b0}) begin
                errors++;
                $display("FAIL reset_repress k=%0d: got %b expected %b", k,
                         {btn_level, btn_press, btn_release}, {k >= 10, k == 10, 1'b0});
            end
        end
    endtask

    task automatic test_auto_repeat();
        int n_rep;
        bit exp_rep;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        n_rep  = 0;
        btn_in = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            tick();
            exp_rep = REP_EN && (k >= 30) && (((k - 30) % 5) == 0);
            if (btn_repeat === 1'b1) n_rep++;
            checks++;
            if ({btn_press, btn_repeat} !== {k == 10, exp_rep}) begin
                errors++;
                $display("FAIL auto_repeat k=%0d: got prs/rep %b expected %b", k,
                         {btn_press, btn_repeat}, {k == 10, exp_rep});
            end
        end
        checks++;
        if (n_rep != (REP_EN ? 9 : 0)) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected %0d", n_rep, REP_EN ? 9 : 0);
        end
        btn_in = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            checks++;
            if (btn_repeat !== m_repeat || btn_release !== m_release) begin
                errors++;
                $display("FAIL repeat_release k=%0d: got rep/rel %b%b expected %b%b", k,
                         btn_repeat, btn_release, m_repeat, m_release);
            end
        end
    endtask

    task automatic test_random();
        int run_len;
        int cyc;
        cyc = 0;
        while (cyc < 3000) begin
            btn_in  = 1'($urandom_range(0, 1));
            run_len = $urandom_range(1, 40);
            if (run_len > 14 && run_len < 30) run_len = run_len - 14;
            for (int j = 0; j < run_len; j++) begin
                rst_n = ($urandom_range(0, 199) != 0);
                tick();
                cyc++;
                checks++;
                if ({btn_level, btn_press, btn_release, btn_repeat} !==
                    {m_level, m_press, m_release, m_repeat}) begin
                    errors++;
                    $display("FAIL random cyc=%0d: got lvl/prs/rel/rep %b expected %b", cyc,
                             {btn_level, btn_press, btn_release, btn_repeat},
                             {m_level, m_press, m_release, m_repeat});
                end
                checks++;
                if ((int'(btn_press) + int'(btn_release) + int'(btn_repeat)) > 1) begin
                    errors++;
                    $display("FAIL strobe_exclusive cyc=%0d: got %b expected at most one", cyc,
                             {btn_press, btn_release, btn_repeat});
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk148);
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_bounce_reject();
        test_reset_mid_press();
        test_auto_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
